// File: rtl/memory_access.sv
// MEM pipeline stage: data-memory handshake, load formatting, store lane steering,
// access fault detection and the MEM/WB pipeline register.
module memory_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_M,
  input  logic        mem_read_M,
  input  logic        mem_write_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] alu_result_M,
  input  logic [31:0] write_data_M,
  input  logic [31:0] pcPlus4_M,
  input  logic [1:0]  result_set_M,
  input  logic [4:0]  rd_M,
  input  logic        reg_write_M,
  output logic        stall_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        valid_WB,
  output logic        reg_write_WB,
  output logic [4:0]  rd_WB,
  output logic [1:0]  result_set_WB,
  output logic [31:0] alu_result_WB,
  output logic [31:0] mem_data_WB,
  output logic [31:0] pcPlus4_WB,
  output logic        mem_exc_WB
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        is_mem;
  logic [1:0]  lane;
  logic        bad;
  logic        access;
  logic        timeout;
  logic        exc;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;
  logic [31:0] load_data;

  // Access qualification and fault detection
  always_comb begin
    is_mem  = mem_read_M | mem_write_M;
    lane    = alu_result_M[1:0];
    bad     = (funct3_M == 3'b011) | (funct3_M == 3'b110) | (funct3_M == 3'b111)
            | ((funct3_M[1:0] == 2'b01) & lane[0])
            | ((funct3_M[1:0] == 2'b10) & (lane != 2'b00));
    access  = valid_M & is_mem & ~bad;
    timeout = access & (state_q == S_WAIT) & (cnt_q >= CNT_LAST) & ~dmem_ready;
    stall_M = access & ~dmem_ready & ~timeout;
    exc     = (valid_M & is_mem & bad) | timeout;
  end

  // Bus request side; the wait counter starts at 1 on entry to WAIT so the
  // request cycle itself counts toward the timeout budget
  always_comb begin
    dmem_req   = access & rst_n;
    dmem_we    = access & mem_write_M;
    dmem_addr  = {alu_result_M[31:2], 2'b00};
    dmem_be    = 4'b0000;
    dmem_wdata = write_data_M;
    case (funct3_M[1:0])
      2'b00:   dmem_wdata = {4{write_data_M[7:0]}};
      2'b01:   dmem_wdata = {2{write_data_M[15:0]}};
      default: dmem_wdata = write_data_M;
    endcase
    if (access & mem_write_M) begin
      case (funct3_M[1:0])
        2'b00:   dmem_be = 4'b0001 << lane;
        2'b01:   dmem_be = lane[1] ? 4'b1100 : 4'b0011;
        2'b10:   dmem_be = 4'b1111;
        default: dmem_be = 4'b0000;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (access & ~dmem_ready) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (~access | dmem_ready | timeout) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load alignment and extension
  always_comb begin
    case (lane)
      2'b00:   byte_sel = dmem_rdata[7:0];
      2'b01:   byte_sel = dmem_rdata[15:8];
      2'b10:   byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_M)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_fmt = {24'h000000, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_fmt = {16'h0000, half_sel};
      3'b010:  load_fmt = dmem_rdata;
      default: load_fmt = 32'h0000_0000;
    endcase
    load_data = (access & mem_read_M & dmem_ready) ? load_fmt : 32'h0000_0000;
  end

  // MEM/WB register; a stall inserts a bubble while data fields hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_WB      <= 1'b0;
      reg_write_WB  <= 1'b0;
      rd_WB         <= 5'd0;
      result_set_WB <= 2'd0;
      alu_result_WB <= 32'h0000_0000;
      mem_data_WB   <= 32'h0000_0000;
      pcPlus4_WB    <= 32'h0000_0000;
      mem_exc_WB    <= 1'b0;
    end else if (stall_M) begin
      valid_WB     <= 1'b0;
      reg_write_WB <= 1'b0;
      mem_exc_WB   <= 1'b0;
    end else begin
      valid_WB      <= valid_M;
      reg_write_WB  <= reg_write_M & valid_M & ~exc;
      rd_WB         <= rd_M;
      result_set_WB <= result_set_M;
      alu_result_WB <= alu_result_M;
      mem_data_WB   <= load_data;
      pcPlus4_WB    <= pcPlus4_M;
      mem_exc_WB    <= exc;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus randomized
// instructions checked against a behavioural model of the MEM stage.
module tb_memory_access;

  localparam int unsigned TO = 4;

  logic        clk, rst_n;
  logic        valid_M, mem_read_M, mem_write_M, reg_write_M;
  logic [2:0]  funct3_M;
  logic [31:0] alu_result_M, write_data_M, pcPlus4_M;
  logic [1:0]  result_set_M;
  logic [4:0]  rd_M;
  logic        stall_M, dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        valid_WB, reg_write_WB, mem_exc_WB;
  logic [4:0]  rd_WB;
  logic [1:0]  result_set_WB;
  logic [31:0] alu_result_WB, mem_data_WB, pcPlus4_WB;

  int checks = 0;
  int errors = 0;

  memory_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_M(valid_M), .mem_read_M(mem_read_M),
    .mem_write_M(mem_write_M), .funct3_M(funct3_M), .alu_result_M(alu_result_M),
    .write_data_M(write_data_M), .pcPlus4_M(pcPlus4_M), .result_set_M(result_set_M),
    .rd_M(rd_M), .reg_write_M(reg_write_M), .stall_M(stall_M), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .valid_WB(valid_WB),
    .reg_write_WB(reg_write_WB), .rd_WB(rd_WB), .result_set_WB(result_set_WB),
    .alu_result_WB(alu_result_WB), .mem_data_WB(mem_data_WB), .pcPlus4_WB(pcPlus4_WB),
    .mem_exc_WB(mem_exc_WB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations gathered by exec for one instruction
  int          o_stalls, o_badbub, o_reqcyc;
  logic        o_hung, o_we0;
  logic [3:0]  o_be0;
  logic [31:0] o_addr0, o_wdata0;
  logic        o_valid, o_rw, o_exc;
  logic [4:0]  o_rd;
  logic [1:0]  o_rs;
  logic [31:0] o_alu, o_mdata, o_pc;

  // ---------------- reference model ----------------
  function automatic logic m_bad(input logic [2:0] f3, input logic [31:0] a);
    int unsigned f, off;
    f = 32'(f3);
    off = a % 4;
    return (f == 3 || f == 6 || f == 7) || ((f == 1 || f == 5) && (off % 2) == 1)
           || (f == 2 && off != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    int unsigned off;
    logic [31:0] b, h;
    off = a % 4;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      3'd2:    return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned off;
    logic [3:0] be;
    off = a % 4;
    be = 4'b0000;
    if (f3 == 3'd0) begin
      for (int i = 0; i < 4; i++) if (i == int'(off)) be[i] = 1'b1;
    end else if (f3 == 3'd1) be = (off < 2) ? 4'b0011 : 4'b1100;
    else if (f3 == 3'd2) be = 4'b1111;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return 32'(d[7:0]) * 32'h0101_0101;
    if (f3 == 3'd1) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  // Drives one instruction (called at posedge+1); memory answers after dly cycles
  task automatic exec(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                      input logic [31:0] pc, input logic [1:0] rs, input logic [4:0] rdi,
                      input logic rw, input int dly);
    logic st;
    valid_M = v; mem_read_M = rd; mem_write_M = wr; funct3_M = f3;
    alu_result_M = addr; write_data_M = wd; pcPlus4_M = pc; result_set_M = rs;
    rd_M = rdi; reg_write_M = rw;
    o_stalls = 0; o_badbub = 0; o_reqcyc = 0; o_hung = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      dmem_ready = (cyc == dly);
      dmem_rdata = (cyc == dly) ? rdata : $urandom;
      @(negedge clk);
      if (cyc == 0) begin
        o_we0 = dmem_we; o_be0 = dmem_be; o_addr0 = dmem_addr; o_wdata0 = dmem_wdata;
      end
      if (dmem_req) o_reqcyc++;
      st = stall_M;
      @(posedge clk); #1;
      if (st) begin
        o_stalls++;
        if (valid_WB !== 1'b0 || reg_write_WB !== 1'b0 || mem_exc_WB !== 1'b0) o_badbub++;
      end else begin
        o_hung = 1'b0;
        o_valid = valid_WB; o_rw = reg_write_WB; o_exc = mem_exc_WB; o_rd = rd_WB;
        o_rs = result_set_WB; o_alu = alu_result_WB; o_mdata = mem_data_WB; o_pc = pcPlus4_WB;
        break;
      end
    end
    dmem_ready = 1'b0;
    valid_M = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    valid_M = 1'b1; mem_read_M = 1'b1; mem_write_M = 1'b0; funct3_M = 3'b010;
    alu_result_M = 32'h100; write_data_M = 32'h0; pcPlus4_M = 32'h4;
    result_set_M = 2'b01; rd_M = 5'd1; reg_write_M = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_req); end
    checks++;
    if ({valid_WB, reg_write_WB, rd_WB, result_set_WB, alu_result_WB, mem_data_WB,
         pcPlus4_WB, mem_exc_WB} !== '0) begin
      errors++; $display("FAIL reset_wb: WB outputs not all zero (valid=%b alu=%h pc=%h)",
                         valid_WB, alu_result_WB, pcPlus4_WB);
    end
    valid_M = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_word;
    exec(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h1004, 2'b01, 5'd5, 1, 0);
    checks++;
    if (o_stalls != 0 || o_hung) begin errors++; $display("FAIL lw_stall: got %0d want 0", o_stalls); end
    checks++;
    if (o_valid !== 1'b1 || o_mdata !== 32'hDEADBEEF || o_rs !== 2'b01 || o_rw !== 1'b1 || o_rd !== 5'd5) begin
      errors++; $display("FAIL lw_wb: got valid=%b data=%h rs=%b rw=%b want 1 deadbeef 01 1",
                         o_valid, o_mdata, o_rs, o_rw);
    end
  endtask

  task automatic test_load_format;
    exec(1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 32'h8, 2'b01, 5'd6, 1, 0);
    checks++;
    if (o_mdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb: got %h want ffffff80", o_mdata); end
    exec(1, 1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 32'hC, 2'b01, 5'd6, 1, 0);
    checks++;
    if (o_mdata !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h want 00000080", o_mdata); end
    exec(1, 1, 0, 3'b101, 32'h102, 32'h0, 32'h80112233, 32'h10, 2'b01, 5'd6, 1, 0);
    checks++;
    if (o_mdata !== 32'h00008011) begin errors++; $display("FAIL lhu: got %h want 00008011", o_mdata); end
    exec(1, 1, 0, 3'b001, 32'h102, 32'h0, 32'h80112233, 32'h14, 2'b01, 5'd6, 1, 1);
    checks++;
    if (o_mdata !== 32'hFFFF8011 || o_stalls != 1) begin
      errors++; $display("FAIL lh_wait1: got %h stalls=%0d want ffff8011 1", o_mdata, o_stalls);
    end
  endtask

  task automatic test_store;
    exec(1, 0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 32'h18, 2'b00, 5'd0, 0, 0);
    checks++;
    if (o_addr0 !== 32'h100 || o_be0 !== 4'b1100 || o_wdata0 !== 32'hABCDABCD || o_we0 !== 1'b1) begin
      errors++; $display("FAIL sh: got addr=%h be=%b wdata=%h we=%b want 100 1100 abcdabcd 1",
                         o_addr0, o_be0, o_wdata0, o_we0);
    end
    checks++;
    if (o_valid !== 1'b1 || o_mdata !== 32'h0 || o_exc !== 1'b0) begin
      errors++; $display("FAIL sh_wb: got valid=%b data=%h exc=%b want 1 0 0", o_valid, o_mdata, o_exc);
    end
  endtask

  task automatic test_wait;
    exec(1, 1, 0, 3'b010, 32'h204, 32'h0, 32'h12345678, 32'h20, 2'b01, 5'd7, 1, 3);
    checks++;
    if (o_stalls != 3 || o_badbub != 0 || o_reqcyc != 4) begin
      errors++; $display("FAIL wait_stall: got stalls=%0d badbub=%0d req=%0d want 3 0 4",
                         o_stalls, o_badbub, o_reqcyc);
    end
    checks++;
    if (o_valid !== 1'b1 || o_mdata !== 32'h12345678 || o_exc !== 1'b0) begin
      errors++; $display("FAIL wait_wb: got valid=%b data=%h exc=%b want 1 12345678 0", o_valid, o_mdata, o_exc);
    end
    exec(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h24, 2'b00, 5'd0, 0, 0);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL wait_single_pulse: got %b want 0", o_valid); end
  endtask

  task automatic test_misaligned;
    exec(1, 1, 0, 3'b010, 32'h101, 32'h0, 32'hFFFFFFFF, 32'h28, 2'b01, 5'd8, 1, 2);
    checks++;
    if (o_reqcyc != 0 || o_stalls != 0) begin
      errors++; $display("FAIL mis_req: got req=%0d stalls=%0d want 0 0", o_reqcyc, o_stalls);
    end
    checks++;
    if (o_exc !== 1'b1 || o_rw !== 1'b0 || o_valid !== 1'b1) begin
      errors++; $display("FAIL mis_wb: got exc=%b rw=%b valid=%b want 1 0 1", o_exc, o_rw, o_valid);
    end
  endtask

  task automatic test_timeout;
    exec(1, 1, 0, 3'b010, 32'h200, 32'h0, 32'h55AA55AA, 32'h2C, 2'b01, 5'd9, 1, 99);
    checks++;
    if (o_stalls != 3 || o_hung) begin
      errors++; $display("FAIL to_stall: got stalls=%0d hung=%b want 3 0", o_stalls, o_hung);
    end
    checks++;
    if (o_exc !== 1'b1 || o_mdata !== 32'h0 || o_rw !== 1'b0 || o_valid !== 1'b1) begin
      errors++; $display("FAIL to_wb: got exc=%b data=%h rw=%b valid=%b want 1 0 0 1",
                         o_exc, o_mdata, o_rw, o_valid);
    end
  endtask

  task automatic test_reset_mid_wait;
    valid_M = 1'b1; mem_read_M = 1'b1; mem_write_M = 1'b0; funct3_M = 3'b010;
    alu_result_M = 32'h300; pcPlus4_M = 32'h30; rd_M = 5'd3; reg_write_M = 1'b1;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_wait_req: got %b want 0", dmem_req); end
    checks++;
    if ({valid_WB, reg_write_WB, rd_WB, result_set_WB, alu_result_WB, mem_data_WB,
         pcPlus4_WB, mem_exc_WB} !== '0) begin
      errors++; $display("FAIL rst_wait_wb: got alu=%h pc=%h want 0 0", alu_result_WB, pcPlus4_WB);
    end
    valid_M = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exec(1, 1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 32'h34, 2'b01, 5'd3, 1, 99);
    checks++;
    if (o_stalls != 3 || o_exc !== 1'b1) begin
      errors++; $display("FAIL rst_wait_after: got stalls=%0d exc=%b want 3 1", o_stalls, o_exc);
    end
  endtask

  task automatic test_random;
    logic v, rd, wr, rw, bad, acc, to, exc_e;
    logic [2:0] f3;
    logic [1:0] rs;
    logic [4:0] rdi;
    logic [31:0] addr, wd, rdata, pc, md_e;
    int dly, op, c_e;
    for (int n = 0; n < 80; n++) begin
      v = ($urandom_range(0, 9) != 0);
      op = $urandom_range(0, 2);
      rd = (op == 0); wr = (op == 1);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2)) 0: f3 = 3'd3; 1: f3 = 3'd6; default: f3 = 3'd7; endcase
      end else if (wr) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 4)) 0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5; endcase
      end
      addr = $urandom; wd = $urandom; rdata = $urandom; pc = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      rs = 2'($urandom_range(0, 3)); rdi = 5'($urandom_range(0, 31)); rw = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 5);

      bad = m_bad(f3, addr);
      acc = v && (rd || wr) && !bad;
      c_e = !acc ? 0 : (dly <= int'(TO - 1) ? dly : int'(TO - 1));
      to = acc && dly > int'(TO - 1);
      exc_e = v && (rd || wr) && (bad || to);
      md_e = (acc && rd && !to) ? m_load(f3, addr, rdata) : 32'h0;

      exec(v, rd, wr, f3, addr, wd, rdata, pc, rs, rdi, rw, dly);
      checks++;
      if (o_hung || o_stalls != c_e || o_badbub != 0 || o_reqcyc != (acc ? c_e + 1 : 0)) begin
        errors++; $display("FAIL rnd_timing[%0d]: got stalls=%0d badbub=%0d req=%0d want stalls=%0d req=%0d",
                           n, o_stalls, o_badbub, o_reqcyc, c_e, acc ? c_e + 1 : 0);
      end
      checks++;
      if (o_valid !== v || o_exc !== exc_e || o_rw !== (rw & v & ~exc_e) || o_mdata !== md_e) begin
        errors++; $display("FAIL rnd_wb[%0d]: got valid=%b exc=%b rw=%b data=%h want %b %b %b %h",
                           n, o_valid, o_exc, o_rw, o_mdata, v, exc_e, rw & v & ~exc_e, md_e);
      end
      checks++;
      if (o_rd !== rdi || o_rs !== rs || o_alu !== addr || o_pc !== pc) begin
        errors++; $display("FAIL rnd_fields[%0d]: got rd=%0d rs=%b alu=%h pc=%h want %0d %b %h %h",
                           n, o_rd, o_rs, o_alu, o_pc, rdi, rs, addr, pc);
      end
      if (acc) begin
        checks++;
        if (o_addr0 !== {addr[31:2], 2'b00} || o_we0 !== wr || o_be0 !== (wr ? m_be(f3, addr) : 4'b0000)
            || (wr && o_wdata0 !== m_wdata(f3, wd))) begin
          errors++; $display("FAIL rnd_bus[%0d]: got addr=%h we=%b be=%b wdata=%h want be=%b wdata=%h",
                             n, o_addr0, o_we0, o_be0, o_wdata0, wr ? m_be(f3, addr) : 4'b0000, m_wdata(f3, wd));
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_word();
    test_load_format();
    test_store();
    test_wait();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
